// File: rtl/drsstc_pkg.sv
// drsstc_pkg: config word layout, interrupter FSM states and config validation
package drsstc_pkg;
  localparam int CONF_PAR_MAX = 4;
  localparam int CONF_PAR_4 = 16;
  localparam int IDX_TON = 0;
  localparam int IDX_PER = 1;
  localparam int IDX_BURST = 2;
  localparam int IDX_GAP = 3;
  typedef logic [CONF_PAR_4-1:0] word_t;
  typedef logic [CONF_PAR_MAX-1:0][CONF_PAR_4-1:0] sh_reg_t;
  typedef struct packed {
    word_t ton;
    word_t period;
    word_t burst_n;
    word_t gap;
  } conf_t;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} intr_state_t;
  // Pull the receiver's word array apart into named fields
  function automatic conf_t unpack_conf(sh_reg_t s);
    return '{ton: s[IDX_TON], period: s[IDX_PER], burst_n: s[IDX_BURST], gap: s[IDX_GAP]};
  endfunction
  // ton<period keeps duty strictly below 100%; a burst needs a non-empty gap
  function automatic logic conf_chk(conf_t c);
    return c.ton != '0 && c.period > word_t'(1) && c.ton < c.period && (c.burst_n == '0 || c.gap != '0);
  endfunction
endpackage

// File: rtl/interrupter_gen_if.sv
// interrupter_gen_if: config delivery and gate-enable outputs of the interrupter
interface interrupter_gen_if;
  import drsstc_pkg::*;
  logic en;
  logic conf_valid;
  sh_reg_t sh_reg;
  logic out;
  logic conf_err;
  logic active;
  modport master (output en, conf_valid, sh_reg, input out, conf_err, active);
  modport slave (input en, conf_valid, sh_reg, output out, conf_err, active);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into one-cycle ticks every PRESCALE cycles, held at zero by clr
module tick_prescaler #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] r_cnt;
  logic w_tc;
  assign w_tc = r_cnt == W'(PRESCALE - 1);
  assign tick = !clr && w_tc;
  // free-running divider, restarted from zero while cleared
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (clr || w_tc) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/interrupter_gen.sv
// interrupter_gen: validated, period-aligned DRSSTC gate-enable pulse train with burst modulation
module interrupter_gen
  import drsstc_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input logic clk,
  input logic rst_n,
  interrupter_gen_if.slave bus
);
  intr_state_t r_state, w_nxt;
  conf_t r_cfg, r_pend_cfg, w_new, w_apply_cfg;
  word_t r_tcnt, r_pulses;
  logic r_cfg_ok, r_pend, r_out, r_err, r_active;
  logic w_tick, w_clr, w_ok, w_accept, w_enter, w_burst_chg;
  assign w_clr = r_state == IDLE;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk),
    .rst_n(rst_n),
    .clr(w_clr),
    .tick(w_tick)
  );
  assign bus.out = r_out;
  assign bus.conf_err = r_err;
  assign bus.active = r_active;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  // next state, config selection at ON entry; en=0 always wins
  always_comb begin
    w_new = unpack_conf(bus.sh_reg);
    w_ok = conf_chk(w_new);
    w_accept = bus.conf_valid && w_ok;
    w_nxt = r_state;
    case (r_state)
      IDLE: if (r_cfg_ok || r_pend) w_nxt = ON;
      ON: if (w_tick && r_tcnt == r_cfg.ton - word_t'(1)) w_nxt = OFF;
      OFF: if (w_tick && r_tcnt == r_cfg.period - r_cfg.ton - word_t'(1))
        w_nxt = (r_cfg.burst_n == '0 || r_pulses < r_cfg.burst_n) ? ON : GAP;
      GAP: if (w_tick && r_tcnt == r_cfg.gap - word_t'(1)) w_nxt = ON;
      default: w_nxt = IDLE;
    endcase
    if (!bus.en) w_nxt = IDLE;
    w_enter = w_nxt == ON && r_state != ON;
    w_apply_cfg = w_accept ? w_new : r_pend ? r_pend_cfg : r_cfg;
    w_burst_chg = w_apply_cfg.burst_n != r_cfg.burst_n;
  end
  // config registers, tick/pulse counters and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cfg <= '0;
      r_pend_cfg <= '0;
      r_cfg_ok <= 1'b0;
      r_pend <= 1'b0;
      r_err <= 1'b0;
      r_tcnt <= '0;
      r_pulses <= '0;
      r_out <= 1'b0;
      r_active <= 1'b0;
    end else begin
      if (bus.conf_valid) r_err <= !w_ok;
      if (w_enter) begin
        r_cfg <= w_apply_cfg;
        r_cfg_ok <= 1'b1;
        r_pend <= 1'b0;
      end else if (w_accept) begin
        r_pend_cfg <= w_new;
        r_pend <= 1'b1;
      end
      r_tcnt <= (w_nxt != r_state) ? '0 : w_tick ? r_tcnt + word_t'(1) : r_tcnt;
      r_pulses <= w_enter ? ((r_state == GAP || w_burst_chg) ? word_t'(1) : r_pulses + word_t'(1))
                : (w_nxt == IDLE) ? '0 : r_pulses;
      r_out <= w_nxt == ON;
      r_active <= w_nxt != IDLE;
    end
endmodule

// File: tb/tb_interrupter_gen.sv
// tb_interrupter_gen: directed vector table plus corner-case sequences for the interrupter
module tb_interrupter_gen;
  import drsstc_pkg::*;
  typedef struct {
    word_t ton;
    word_t per;
    word_t bn;
    word_t gap;
    logic exp_err;
    logic [0:23] exp_wave;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  vec_t vecs[10];
  logic [0:23] wo, wa, wo4;
  logic e0, ef, hi;
  interrupter_gen_if bus();
  interrupter_gen_if bus4();
  assign bus4.en = bus.en;
  assign bus4.conf_valid = bus.conf_valid;
  assign bus4.sh_reg = bus.sh_reg;
  interrupter_gen #(.PRESCALE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  interrupter_gen #(.PRESCALE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  always #5 clk = ~clk;

  function automatic sh_reg_t mk(word_t t, word_t p, word_t b, word_t g);
    sh_reg_t s;
    s[IDX_TON] = t;
    s[IDX_PER] = p;
    s[IDX_BURST] = b;
    s[IDX_GAP] = g;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic strobe(input sh_reg_t s);
    bus.sh_reg = s;
    bus.conf_valid = 1'b1;
    @(posedge clk);
    #1 bus.conf_valid = 1'b0;
  endtask

  // reset, load cfg, raise en and record 24 cycles; optional strobe at edge sj, en drop at edge dj
  task automatic run(input sh_reg_t cfg, input int sj, input sh_reg_t scfg, input int dj,
                     output logic [0:23] o, output logic [0:23] a, output logic [0:23] o4,
                     output logic err0, output logic errf);
    bus.en = 1'b0;
    bus.conf_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    strobe(cfg);
    err0 = bus.conf_err;
    bus.en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == sj) begin
        bus.sh_reg = scfg;
        bus.conf_valid = 1'b1;
      end
      if (i == dj) bus.en = 1'b0;
      @(posedge clk);
      #1 bus.conf_valid = 1'b0;
      o[i] = bus.out;
      a[i] = bus.active;
      o4[i] = bus4.out;
    end
    errf = bus.conf_err;
    bus.en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'd3, 16'd10, 16'd0, 16'd0, 1'b0, 24'b1110000000_1110000000_1110};
    vecs[1] = '{16'd2, 16'd5, 16'd2, 16'd4, 1'b0, 24'b11000_11000_0000_11000_11000};
    vecs[2] = '{16'd1, 16'd2, 16'd0, 16'd0, 1'b0, 24'b101010101010101010101010};
    vecs[3] = '{16'd10, 16'd10, 16'd0, 16'd0, 1'b1, 24'b0};
    vecs[4] = '{16'd0, 16'd5, 16'd0, 16'd0, 1'b1, 24'b0};
    vecs[5] = '{16'd3, 16'd2, 16'd0, 16'd0, 1'b1, 24'b0};
    vecs[6] = '{16'd1, 16'd1, 16'd0, 16'd0, 1'b1, 24'b0};
    vecs[7] = '{16'd2, 16'd5, 16'd3, 16'd0, 1'b1, 24'b0};
    vecs[8] = '{16'd4, 16'd5, 16'd0, 16'd0, 1'b0, 24'b11110_11110_11110_11110_1111};
    vecs[9] = '{16'd1, 16'd3, 16'd1, 16'd2, 1'b0, 24'b10000_10000_10000_10000_1000};
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.conf_valid = 1'b0;
    bus.sh_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(bus.out), 32'd0);
    check("reset_active", 32'(bus.active), 32'd0);
    check("reset_err", 32'(bus.conf_err), 32'd0);
    check("reset_out4", 32'(bus4.out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run(mk(vecs[i].ton, vecs[i].per, vecs[i].bn, vecs[i].gap), -1, '0, -1, wo, wa, wo4, e0, ef);
      check($sformatf("vec%0d_err", i), 32'(e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_wave", i), 32'(wo), 32'(vecs[i].exp_wave));
      check($sformatf("vec%0d_active", i), 32'(wa), vecs[i].exp_err ? 32'd0 : 32'hFFFFFF);
    end
    run(mk(3, 10, 0, 0), 5, mk(10, 10, 0, 0), -1, wo, wa, wo4, e0, ef);
    check("bad_midrun_wave", 32'(wo), 32'(24'b1110000000_1110000000_1110));
    check("bad_midrun_err", 32'(ef), 32'd1);
    strobe(mk(3, 10, 0, 0));
    check("err_cleared", 32'(bus.conf_err), 32'd0);
    run(mk(3, 10, 0, 0), 1, mk(5, 10, 0, 0), -1, wo, wa, wo4, e0, ef);
    check("midon_change_wave", 32'(wo), 32'(24'b1110000000_1111100000_1111));
    run(mk(3, 10, 0, 0), 10, mk(5, 10, 0, 0), -1, wo, wa, wo4, e0, ef);
    check("apply_point_wave", 32'(wo), 32'(24'b1110000000_1111100000_1111));
    run(mk(3, 10, 0, 0), -1, '0, 2, wo, wa, wo4, e0, ef);
    check("en_drop_wave", 32'(wo), 32'(24'b11 << 22));
    check("en_drop_active", 32'(wa), 32'(24'b11 << 22));
    run(mk(1, 2, 0, 0), -1, '0, -1, wo, wa, wo4, e0, ef);
    check("prescale4_wave", 32'(wo4), 32'(24'b11110000_11110000_11110000));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    strobe(mk(3, 10, 0, 0));
    bus.en = 1'b1;
    @(posedge clk);
    #1 check("pre_reset_out", 32'(bus.out), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_out", 32'(bus.out), 32'd0);
    check("async_reset_active", 32'(bus.active), 32'd0);
    #1 rst_n = 1'b1;
    hi = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 hi = hi | bus.out | bus.active;
    end
    check("post_reset_idle", 32'(hi), 32'd0);
    bus.en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
